// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Launches one byte at a time, waits for the transmitter to start and finish,
// then enforces an idle gap before the next grant.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [1:0] req0_cfg,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [1:0] req1_cfg,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       tx_two_stop,
  output logic       tx_odd_parity,
  output logic       grant_id,
  output logic       busy,
  input  logic       err_clr,
  output logic       err_timeout
);

  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES) + 1;
  localparam int unsigned START_W    = $clog2(START_TIMEOUT) + 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned START_LAST = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [START_W-1:0]   start_cnt_q, start_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 two_stop_q, two_stop_d;
  logic                 odd_par_q, odd_par_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic                 pick0, pick1;
  logic                 err_set;

  // Arbitration, next-state and datapath capture
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_data_d   = tx_data_q;
    two_stop_d  = two_stop_q;
    odd_par_d   = odd_par_q;
    grant_d     = grant_q;
    last_d      = last_q;
    err_set     = 1'b0;

    // On a tie the requester that was not granted last wins
    pick1      = req1_valid && (!req0_valid || !last_q);
    pick0      = req0_valid && !pick1;
    req0_ready = (state_q == S_IDLE) && pick0;
    req1_ready = (state_q == S_IDLE) && pick1;

    case (state_q)
      S_IDLE: begin
        if (pick0 || pick1) begin
          tx_data_d  = pick1 ? req1_data : req0_data;
          two_stop_d = pick1 ? req1_cfg[1] : req0_cfg[1];
          odd_par_d  = pick1 ? req1_cfg[0] : req0_cfg[0];
          grant_d    = pick1;
          last_d     = pick1;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_cnt_d = '0;
        state_d     = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (start_cnt_q == START_W'(START_LAST)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          start_cnt_d = start_cnt_q + START_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky timeout flag; a new timeout outranks a clear in the same cycle
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_cnt_q <= '0;
      gap_cnt_q   <= '0;
      tx_data_q   <= '0;
      two_stop_q  <= 1'b0;
      odd_par_q   <= 1'b0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_data_q   <= tx_data_d;
      two_stop_q  <= two_stop_d;
      odd_par_q   <= odd_par_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  // Launch strobe is suppressed while reset is held so an abandoned frame never starts
  assign tx_en         = (state_q == S_LAUNCH) && !rst;
  assign busy          = (state_q != S_IDLE);
  assign tx_data       = tx_data_q;
  assign tx_two_stop   = two_stop_q;
  assign tx_odd_parity = odd_par_q;
  assign grant_id      = grant_q;
  assign err_timeout   = err_q;

endmodule
